// File: rtl/mem_responder_pkg.sv
// Shared types and bus widths for the memory responder.
// Provides the memory bus widths (address, data, strobe), the matching
// typedefs, and a byte-merge helper used for strobed writes.
package mem_responder_pkg;

   localparam int MEM_ADDR_R = 63;
   localparam int MEM_DATA_R = 63;
   localparam int MEM_STRB_R = 7;

   typedef logic [MEM_ADDR_R:0] addr_t;
   typedef logic [MEM_DATA_R:0] data_t;
   typedef logic [MEM_STRB_R:0] strb_t;

   // Replace the bytes of old_word selected by strb with the bytes of new_word.
   function automatic data_t merge_bytes(data_t old_word, data_t new_word, strb_t strb);
      data_t res;
      res = old_word;
      for (int k = 0; k <= MEM_STRB_R; k++) begin
         if (strb[k]) res[8*k +: 8] = new_word[8*k +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Core memory bus (req/gnt handshake with a registered response).
// master: drives mem_req/addr/wen/strb/wdata, receives mem_gnt/err/rdata.
// slave : the responder side of the same bus.
interface mem_responder_if;
   import mem_responder_pkg::*;

   logic  mem_req;
   logic  mem_gnt;
   logic  mem_wen;
   addr_t mem_addr;
   strb_t mem_strb;
   data_t mem_wdata;
   logic  mem_err;
   data_t mem_rdata;

   modport master (
      output mem_req, mem_addr, mem_wen, mem_strb, mem_wdata,
      input  mem_gnt, mem_err, mem_rdata
   );

   modport slave (
      input  mem_req, mem_addr, mem_wen, mem_strb, mem_wdata,
      output mem_gnt, mem_err, mem_rdata
   );

endinterface

// File: rtl/mem_responder_lfsr.sv
// 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, steps every cycle.
// Ports:
//   g_clk    in   clock
//   g_resetn in   async active-low reset, loads SEED
//   value    out  current LFSR state
module mem_responder_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        g_clk,
   input  logic        g_resetn,
   output logic [15:0] value
);

   // Right-shifting Galois form: the feedback bit is XORed into the tap
   // positions of the shifted word.
   localparam logic [15:0] TAPS = 16'hB400;

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) value <= SEED;
      else           value <= {1'b0, value[15:1]} ^ (value[0] ? TAPS : 16'h0000);
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder of the core req/gnt bus, backed by a word RAM.
// Grants after a bounded pseudo-random stall and returns rdata/err in the
// cycle after the transfer.
// Ports:
//   g_clk     in   clock
//   g_resetn  in   async active-low reset
//   cfg_stall in   1 = random stalls enabled, 0 = grant immediately
//   bus       slave modport: mem_req/addr/wen/strb/wdata in,
//             mem_gnt (combinational), mem_err/mem_rdata (registered) out
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter addr_t       BASE_ADDR   = 64'h0000_0000_8000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          MAX_DELAY   = 4,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic             g_clk,
   input  logic             g_resetn,
   input  logic             cfg_stall,
   mem_responder_if.slave   bus
);

   localparam int    BYTES = MEM_STRB_R + 1;
   localparam int    OFF_W = $clog2(BYTES);
   localparam int    IDX_W = $clog2(DEPTH_WORDS);
   localparam int    CNT_W = (MAX_DELAY > 0) ? $clog2(MAX_DELAY + 1) : 1;
   localparam addr_t SPAN  = addr_t'(DEPTH_WORDS) << OFF_W;

   typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   stall_cnt, stall_cnt_nxt;
   logic [15:0]        lfsr;
   logic [7:0]         d_raw;
   logic [CNT_W-1:0]   delay;
   logic               gnt_c;
   logic               xfer;
   addr_t              offset;
   logic               in_range;
   logic [IDX_W-1:0]   idx;
   data_t              ram [DEPTH_WORDS];

   mem_responder_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .g_clk    (g_clk),
      .g_resetn (g_resetn),
      .value    (lfsr)
   );

   // Only the low byte feeds the delay draw.
   logic unused_lfsr_hi;
   assign unused_lfsr_hi = ^lfsr[15:8];

   assign d_raw = cfg_stall ? (lfsr[7:0] % 8'(MAX_DELAY + 1)) : 8'd0;
   assign delay = CNT_W'(d_raw);

   // ---------------- grant FSM ----------------
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state     <= IDLE;
         stall_cnt <= '0;
      end else begin
         state     <= state_nxt;
         stall_cnt <= stall_cnt_nxt;
      end
   end

   // The IDLE cycle that draws a non-zero delay is itself the first stall
   // cycle, so STALL holds delay-1 more cycles before granting.
   always_comb begin
      state_nxt     = state;
      stall_cnt_nxt = stall_cnt;
      gnt_c         = 1'b0;
      case (state)
         IDLE: begin
            if (bus.mem_req) begin
               if (delay == '0) begin
                  gnt_c = 1'b1;
               end else begin
                  stall_cnt_nxt = delay - 1'b1;
                  state_nxt     = STALL;
               end
            end
         end
         STALL: begin
            if (!bus.mem_req) begin
               // requester abandoned the request: drop it
               stall_cnt_nxt = '0;
               state_nxt     = IDLE;
            end else if (stall_cnt == '0) begin
               gnt_c     = 1'b1;
               state_nxt = IDLE;
            end else begin
               stall_cnt_nxt = stall_cnt - 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Gate with reset: during reset the FSM sits in IDLE and could otherwise
   // grant combinationally.
   assign bus.mem_gnt = gnt_c & g_resetn;
   assign xfer        = bus.mem_req & bus.mem_gnt;

   // ---------------- address decode ----------------
   // A wrap below BASE_ADDR yields a huge offset; the explicit lower-bound
   // compare keeps that out of range for any BASE_ADDR.
   assign offset   = bus.mem_addr - BASE_ADDR;
   assign in_range = (bus.mem_addr >= BASE_ADDR) && (offset < SPAN);
   assign idx      = offset[OFF_W +: IDX_W];

   // ---------------- RAM (not reset) ----------------
   always_ff @(posedge g_clk) begin
      if (xfer && bus.mem_wen && in_range)
         ram[idx] <= merge_bytes(ram[idx], bus.mem_wdata, bus.mem_strb);
   end

   // ---------------- response ----------------
   // err is a single-cycle pulse; rdata holds until the next transfer.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         bus.mem_err   <= 1'b0;
         bus.mem_rdata <= '0;
      end else if (xfer) begin
         if (!in_range) begin
            bus.mem_err   <= 1'b1;
            bus.mem_rdata <= '0;
         end else if (bus.mem_wen) begin
            bus.mem_err   <= 1'b0;
            bus.mem_rdata <= '0;
         end else begin
            bus.mem_err   <= 1'b0;
            bus.mem_rdata <= ram[idx];
         end
      end else begin
         bus.mem_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, randomized
// traffic against a word-array memory model, reset-mid-stall and
// back-to-back sequences.
module tb_mem_responder;
   import mem_responder_pkg::*;

   localparam addr_t       BASE  = 64'h0000_0000_8000_0000;
   localparam int          DEPTH = 1024;
   localparam int          MAXD  = 4;
   localparam logic [15:0] SEED  = 16'hACE1;
   localparam addr_t       TOP   = BASE + 64'(DEPTH * 8);

   logic g_clk = 1'b0;
   logic g_resetn = 1'b0;
   logic cfg_stall = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   mem_responder_if bus();

   mem_responder #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (DEPTH),
      .MAX_DELAY   (MAXD),
      .LFSR_SEED   (SEED)
   ) dut (
      .g_clk     (g_clk),
      .g_resetn  (g_resetn),
      .cfg_stall (cfg_stall),
      .bus       (bus)
   );

   always #5 g_clk = ~g_clk;
   always @(posedge g_clk) cyc <= cyc + 1;

   data_t mram [DEPTH];
   int    hist [MAXD+1];

   typedef struct {
      logic  wen;
      addr_t addr;
      strb_t strb;
      data_t wdata;
      logic  exp_err;
      data_t exp_rdata;
   } vec_t;
   vec_t tab [12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Call at #1 after a posedge; returns at #1 after the transfer edge with
   // the response visible and req dropped.
   task automatic xfer(input logic wen, input addr_t a, input strb_t s, input data_t w,
                       output int stalls, output bit ok, output int gcyc);
      bus.mem_req = 1'b1; bus.mem_wen = wen; bus.mem_addr = a;
      bus.mem_strb = s;   bus.mem_wdata = w;
      stalls = 0; ok = 1'b0; gcyc = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge g_clk);
         if (bus.mem_gnt === 1'b1) begin ok = 1'b1; gcyc = cyc; break; end
         stalls++;
      end
      @(posedge g_clk); #1;
      bus.mem_req = 1'b0;
   endtask

   task automatic do_chk(input string nm, input logic wen, input addr_t a, input strb_t s,
                         input data_t w, input logic eerr, input data_t erd, input int maxst);
      int st; bit ok; int gc;
      xfer(wen, a, s, w, st, ok, gc);
      chk({nm, " granted"}, 64'(ok), 64'd1);
      checks++;
      if (st > maxst) begin
         errors++;
         $display("FAIL %s stall: got %0d cycles, limit %0d", nm, st, maxst);
      end
      chk({nm, " err"}, 64'(bus.mem_err), 64'(eerr));
      chk({nm, " rdata"}, bus.mem_rdata, erd);
   endtask

   function automatic bit in_rng(addr_t a);
      return (a >= BASE) && (a < TOP);
   endfunction

   initial begin
      int st, gc, prev_gc, n_ok;
      bit ok, found;
      addr_t a;
      data_t w, exp;
      strb_t s;
      logic wen;
      logic [15:0] seed_v;
      int r, wi, d0;

      bus.mem_req = 1'b1; bus.mem_wen = 1'b0; bus.mem_addr = BASE;
      bus.mem_strb = '0;  bus.mem_wdata = '0;
      cfg_stall = 1'b1;

      // ---- reset state: no grant even with req held ----
      #12;
      chk("reset gnt", 64'(bus.mem_gnt), 64'd0);
      chk("reset err", 64'(bus.mem_err), 64'd0);
      chk("reset rdata", bus.mem_rdata, 64'd0);
      bus.mem_req = 1'b0;
      cfg_stall = 1'b0;
      @(negedge g_clk); g_resetn = 1'b1;
      @(posedge g_clk); #1;

      // ---- directed table, no stalls ----
      tab[0]  = '{1'b1, BASE + 64'd8,  8'hFF, 64'h1122334455667788, 1'b0, 64'h0};
      tab[1]  = '{1'b0, BASE + 64'd8,  8'h00, 64'h0,                1'b0, 64'h1122334455667788};
      tab[2]  = '{1'b1, BASE + 64'd16, 8'hFF, 64'h0,                1'b0, 64'h0};
      tab[3]  = '{1'b1, BASE + 64'd16, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0};
      tab[4]  = '{1'b0, BASE + 64'd16, 8'h00, 64'h0,                1'b0, 64'h0000_0000_FFFF_FFFF};
      tab[5]  = '{1'b0, BASE - 64'd8,  8'h00, 64'h0,                1'b1, 64'h0};
      tab[6]  = '{1'b0, TOP,           8'h00, 64'h0,                1'b1, 64'h0};
      tab[7]  = '{1'b1, TOP,           8'hFF, 64'hDEAD_BEEF,        1'b1, 64'h0};
      tab[8]  = '{1'b1, BASE - 64'd8,  8'hFF, 64'hDEAD_BEEF,        1'b1, 64'h0};
      tab[9]  = '{1'b0, BASE + 64'd16, 8'h00, 64'h0,                1'b0, 64'h0000_0000_FFFF_FFFF};
      tab[10] = '{1'b1, TOP - 64'd8,   8'hFF, 64'hCAFE_F00D_0123_4567, 1'b0, 64'h0};
      tab[11] = '{1'b0, TOP - 64'd3,   8'h00, 64'h0,                1'b0, 64'hCAFE_F00D_0123_4567};
      for (int i = 0; i < 12; i++)
         do_chk($sformatf("vec%0d", i), tab[i].wen, tab[i].addr, tab[i].strb, tab[i].wdata,
                tab[i].exp_err, tab[i].exp_rdata, 0);

      // ---- err is a pulse, rdata holds ----
      do_chk("err pulse src", 1'b0, BASE - 64'd8, 8'h00, 64'h0, 1'b1, 64'h0, 0);
      @(posedge g_clk); #1;
      chk("err cleared", 64'(bus.mem_err), 64'd0);
      do_chk("hold src", 1'b0, BASE + 64'd9, 8'h00, 64'h0, 1'b0, 64'h1122334455667788, 0);
      @(posedge g_clk); #1;
      @(posedge g_clk); #1;
      chk("rdata hold", bus.mem_rdata, 64'h1122334455667788);
      chk("hold err", 64'(bus.mem_err), 64'd0);

      // ---- randomized traffic with stalls ----
      cfg_stall = 1'b1;
      for (int k = 0; k <= MAXD; k++) hist[k] = 0;
      for (int k = 0; k < 16; k++) begin
         w = {$urandom, $urandom};
         mram[k] = w;
         do_chk("init", 1'b1, BASE + 64'(k * 8), 8'hFF, w, 1'b0, 64'h0, MAXD);
      end
      n_ok = 0;
      for (int n = 0; n < 2500; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      a = BASE - 64'(8 * $urandom_range(1, 4));
         else if (r == 1) a = TOP + 64'(8 * $urandom_range(0, 3));
         else             a = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
         wen = 1'($urandom_range(0, 1));
         s = 8'($urandom);
         w = {$urandom, $urandom};
         xfer(wen, a, s, w, st, ok, gc);
         checks++;
         if (!ok || st > MAXD) begin
            errors++;
            $display("FAIL rand stall n=%0d: granted=%0d stalls=%0d limit %0d", n, ok, st, MAXD);
         end else begin
            hist[st]++;
         end
         if (!in_rng(a)) begin
            chk("rand oor err", 64'(bus.mem_err), 64'd1);
            chk("rand oor rdata", bus.mem_rdata, 64'h0);
            exp = 64'h0;
         end else begin
            wi = int'((a - BASE) / 8);
            if (wen) begin
               for (int b = 0; b < 8; b++)
                  if (s[b]) mram[wi][8*b +: 8] = w[8*b +: 8];
               exp = 64'h0;
            end else begin
               exp = mram[wi];
            end
            chk("rand err", 64'(bus.mem_err), 64'd0);
            chk("rand rdata", bus.mem_rdata, exp);
         end
         if ($urandom_range(0, 7) == 0) begin
            @(posedge g_clk); #1;
            chk("rand idle err", 64'(bus.mem_err), 64'd0);
            chk("rand idle rdata", bus.mem_rdata, exp);
         end
      end
      for (int k = 1; k <= MAXD; k++) begin
         checks++;
         if (hist[k] == 0) begin
            errors++;
            $display("FAIL stall coverage: stall of %0d cycles seen 0 times, need at least 1", k);
         end
      end

      // ---- reset asserted while stalling ----
      cfg_stall = 1'b0;
      do_chk("pre-reset read", 1'b0, BASE + 64'd8, 8'h00, 64'h0, 1'b0, mram[1], 0);
      cfg_stall = 1'b1;
      found = 1'b0;
      for (int t = 0; t < 40 && !found; t++) begin
         bus.mem_req = 1'b1; bus.mem_wen = 1'b0; bus.mem_addr = BASE + 64'd8;
         @(negedge g_clk);
         if (bus.mem_gnt === 1'b0) found = 1'b1;
         @(posedge g_clk); #1;
         if (!found) bus.mem_req = 1'b0;
      end
      chk("stall reached", 64'(found), 64'd1);
      g_resetn = 1'b0;
      #1;
      chk("mid-stall rst gnt", 64'(bus.mem_gnt), 64'd0);
      chk("mid-stall rst err", 64'(bus.mem_err), 64'd0);
      chk("mid-stall rst rdata", bus.mem_rdata, 64'h0);
      @(posedge g_clk);
      @(negedge g_clk);
      chk("in-rst gnt", 64'(bus.mem_gnt), 64'd0);
      g_resetn = 1'b1;
      #1;
      chk("lfsr seed", 64'(dut.lfsr), 64'(SEED));
      // First cycle out of reset draws from the seed's low byte.
      seed_v = SEED;
      d0 = int'(seed_v[7:0]) % (MAXD + 1);
      chk("post-rst gnt", 64'(bus.mem_gnt), (d0 == 0) ? 64'd1 : 64'd0);
      bus.mem_req = 1'b0;
      @(posedge g_clk); #1;
      do_chk("post-rst read", 1'b0, BASE + 64'd8, 8'h00, 64'h0, 1'b0, mram[1], MAXD);

      // ---- back-to-back reads, one grant per cycle ----
      cfg_stall = 1'b0;
      prev_gc = 0;
      for (int k = 0; k < 4; k++) begin
         xfer(1'b0, BASE + 64'((4 + k) * 8), 8'h00, 64'h0, st, ok, gc);
         chk($sformatf("b2b%0d granted", k), 64'(ok), 64'd1);
         chk($sformatf("b2b%0d rdata", k), bus.mem_rdata, mram[4 + k]);
         if (k > 0) chk($sformatf("b2b%0d cycle", k), 64'(gc - prev_gc), 64'd1);
         prev_gc = gc;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time exceeded, required completion");
      $fatal(1, "timeout");
   end

endmodule
